ps_serializer: RTL and testbench

Parallel-to-serial transmitter with valid/ready handshakes on both sides. It accepts one M*N-bit word and emits it as M consecutive N-bit beats, most-significant beat first. This order lets a serial-to-parallel shift register that shifts in at the LSB end rebuild the original word. It sits at the transmit end of narrow datapaths and supports back-to-back words with no bubble cycles.

---
 rtl/ps_pkg.sv | 10 +
 rtl/ps_beat_counter.sv | 25 ++
 rtl/ps_serializer.sv | 64 ++++++
 tb/tb_ps_serializer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ps_pkg.sv
// Shared types and helpers for the parallel-to-serial transmit path.
package ps_pkg;

  typedef enum logic {PS_IDLE, PS_BUSY} ps_state_t;

  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/ps_beat_counter.sv
// Modulo-M beat counter with clear, increment and terminal-count flag.
module ps_beat_counter #(
  parameter int unsigned M = 2,
  parameter int unsigned W = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(M - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ps_serializer.sv
// Serializes an M*N-bit word into M N-bit beats, most-significant beat first.
module ps_serializer
  import ps_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M*N-1:0] pdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   sout,
  output logic           last
);

  localparam int unsigned W = cnt_width(M);

  ps_state_t      state;
  logic [M*N-1:0] word;
  logic           tc;
  logic           load;
  logic           beat;

  assign out_valid = (state == PS_BUSY);
  assign sout      = word[M*N-1 -: N];
  assign last      = out_valid & tc;
  // Ready during the final accepted beat lets a new word follow with no bubble.
  assign in_ready  = (state == PS_IDLE) | (out_valid & out_ready & last);
  assign load      = in_valid & in_ready;
  assign beat      = out_valid & out_ready;

  ps_beat_counter #(
    .M(M),
    .W(W)
  ) u_count (
    .clk  (clk),
    .reset(reset),
    .clear(load),
    .inc  (beat),
    .tc   (tc)
  );

  // A load can only coincide with a beat on the last beat, so it takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PS_IDLE;
      word  <= '0;
    end else if (load) begin
      state <= PS_BUSY;
      word  <= pdata;
    end else if (beat) begin
      if (last) begin
        state <= PS_IDLE;
        word  <= '0;
      end else begin
        word <= word << N;
      end
    end
  end

endmodule

// File: tb/tb_ps_serializer.sv
// Checks two serializer configurations against a beat-queue model of the word stream.
module tb_ps_serializer;

  typedef struct {
    logic [7:0] v;
    logic       last;
    logic [7:0] w;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       iv[2];
  logic       ordy[2];
  logic [7:0] pd[2];
  logic       ir[2];
  logic       ov[2];
  logic       lst[2];
  logic [7:0] so[2];
  logic [3:0] sout_a;
  logic [7:0] sout_b;

  int unsigned nb[2] = '{4, 8};
  int unsigned mb[2] = '{2, 1};
  beat_t       q[2][$];
  logic [7:0]  sp[2];
  bit          started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ps_serializer #(.N(4), .M(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .pdata(pd[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sout(sout_a), .last(lst[0])
  );

  ps_serializer #(.N(8), .M(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .pdata(pd[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sout(sout_b), .last(lst[1])
  );

  assign so[0] = {4'h0, sout_a};
  assign so[1] = sout_b;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    logic       e_ov;
    logic       e_ir;
    logic [7:0] e_so;
    logic       e_last;
    logic [7:0] mask;
    e_ov   = (q[k].size() > 0);
    e_so   = e_ov ? q[k][0].v : 8'h00;
    e_last = e_ov ? q[k][0].last : 1'b0;
    e_ir   = !e_ov || (ordy[k] && q[k][0].last);
    chk($sformatf("out_valid%0d", k), {31'b0, ov[k]}, {31'b0, e_ov});
    chk($sformatf("sout%0d", k), {24'b0, so[k]}, {24'b0, e_so});
    chk($sformatf("last%0d", k), {31'b0, lst[k]}, {31'b0, e_last});
    chk($sformatf("in_ready%0d", k), {31'b0, ir[k]}, {31'b0, e_ir});
    if (!reset) begin
      if (e_ov && ordy[k]) begin
        sp[k] = (sp[k] << nb[k]) | so[k];
        if (q[k][0].last) chk($sformatf("deser%0d", k), {24'b0, sp[k]}, {24'b0, q[k][0].w});
        void'(q[k].pop_front());
      end
      if (iv[k] && e_ir) begin
        mask = 8'((16'h1 << nb[k]) - 1);
        for (int unsigned i = 0; i < mb[k]; i++) begin
          beat_t b;
          b.v    = (pd[k] >> (nb[k] * (mb[k] - 1 - i))) & mask;
          b.last = (i == mb[k] - 1);
          b.w    = pd[k];
          q[k].push_back(b);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (started) begin
      model_step(0);
      model_step(1);
    end
    if (reset) begin
      q[0].delete();
      q[1].delete();
      started = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; pd[k] = 8'h00; sp[k] = 8'h00;
    end
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, ir[0]}, 32'd1);
    chk("rst_out_valid", {31'b0, ov[0]}, 32'd0);
    chk("rst_sout", {28'b0, sout_a}, 32'd0);
    chk("rst_last", {31'b0, lst[0]}, 32'd0);

    // Basic word, out_ready held high.
    iv[0] = 1'b1; pd[0] = 8'hA5; ordy[0] = 1'b1;
    tick(); iv[0] = 1'b0; #1;
    chk("t2_beat0", {27'b0, lst[0], sout_a}, {27'b0, 1'b0, 4'hA});
    tick(); #1;
    chk("t2_beat1", {27'b0, lst[0], sout_a}, {27'b0, 1'b1, 4'h5});
    tick(); #1;
    chk("t2_idle", {30'b0, ov[0], ir[0]}, 32'b01);

    // Backpressure holds the first beat.
    iv[0] = 1'b1; pd[0] = 8'hA5; ordy[0] = 1'b0;
    tick(); iv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_hold", {26'b0, ov[0], ir[0], sout_a}, {26'b0, 1'b1, 1'b0, 4'hA});
      tick();
    end
    ordy[0] = 1'b1; #1;
    chk("t3_rel0", {28'b0, sout_a}, 32'hA);
    tick(); #1;
    chk("t3_rel1", {28'b0, sout_a}, 32'h5);
    tick();

    // Back-to-back words.
    iv[0] = 1'b1; pd[0] = 8'h3C;
    tick(); iv[0] = 1'b0; #1;
    chk("t4_b0", {27'b0, lst[0], sout_a}, {27'b0, 1'b0, 4'h3});
    tick();
    iv[0] = 1'b1; pd[0] = 8'hE1; #1;
    chk("t4_b1", {26'b0, ir[0], lst[0], sout_a}, {26'b0, 1'b1, 1'b1, 4'hC});
    tick(); iv[0] = 1'b0; #1;
    chk("t4_b2", {27'b0, ov[0], sout_a}, {27'b0, 1'b1, 4'hE});
    tick(); #1;
    chk("t4_b3", {27'b0, lst[0], sout_a}, {27'b0, 1'b1, 4'h1});
    tick(); #1;
    chk("t4_idle", {31'b0, ov[0]}, 32'd0);

    // Reset mid-word discards the rest.
    iv[0] = 1'b1; pd[0] = 8'h96;
    tick(); iv[0] = 1'b0; #1;
    chk("t5_b0", {28'b0, sout_a}, 32'h9);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("t5_rst", {26'b0, ov[0], ir[0], sout_a}, {26'b0, 1'b0, 1'b1, 4'h0});
    iv[0] = 1'b1; pd[0] = 8'h12;
    tick(); iv[0] = 1'b0; #1;
    chk("t5_n0", {28'b0, sout_a}, 32'h1);
    tick(); #1;
    chk("t5_n1", {28'b0, sout_a}, 32'h2);
    tick();

    // Single-beat configuration at full rate.
    iv[1] = 1'b1; ordy[1] = 1'b1; pd[1] = 8'h11;
    tick(); pd[1] = 8'h22; #1;
    chk("t6_w0", {23'b0, ir[1], lst[1], sout_b}, {23'b0, 1'b1, 1'b1, 8'h11});
    tick(); pd[1] = 8'h33; #1;
    chk("t6_w1", {23'b0, lst[1], sout_b}, {23'b0, 1'b1, 8'h22});
    tick(); iv[1] = 1'b0; #1;
    chk("t6_w2", {23'b0, lst[1], sout_b}, {23'b0, 1'b1, 8'h33});
    tick(); #1;
    chk("t6_idle", {31'b0, ov[1]}, 32'd0);

    // Random traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom_range(0, 3) != 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
        pd[k]   = 8'($urandom);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    for (int c = 0; c < 4; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
